// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Load-use and mult/div structural hazard detection for the five-stage core.
// Drives PC / IF/ID / ID/EX enables, sequences the mult/div busy window and
// keeps a saturating stall-cycle counter. All control outputs are
// combinational and forced low while rst_n is asserted.
module hazard_stall_controller #(
    parameter int BIT_WIDTH  = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] IF_ID_Rs,
    input  logic [BIT_WIDTH-1:0] IF_ID_Rt,
    input  logic                 IF_ID_MdUse,
    input  logic [BIT_WIDTH-1:0] ID_EX_Rt,
    input  logic                 ID_EX_MemRead,
    input  logic                 ID_EX_MdStart,
    input  logic                 EX_BranchTaken,
    input  logic                 ID_Jump,
    input  logic                 StallCntClr,
    output logic                 PC_Write,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Bubble,
    output logic                 MD_Start,
    output logic                 MD_Busy,
    output logic                 MD_Done,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_MD_RUN = 1'b1;

    localparam logic [CW-1:0]        LP_CNT_INIT = CW'(MD_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] LP_SAT_MAX  = '1;

    logic [0:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic w_lu;
    logic w_st;
    logic w_stall;
    logic w_md_busy;
    logic w_md_start;
    logic w_md_done;

    // Hazard detection; a taken branch squashes the ID instruction, so it
    // cancels any stall that instruction would have caused.
    always_comb begin
        w_md_busy  = rst_n && (r_state == S_MD_RUN);
        w_md_done  = w_md_busy && (r_cnt == '0);
        // A start in MD_RUN is illegal and ignored; a squashed EX slot never starts.
        w_md_start = rst_n && (r_state == S_IDLE) && ID_EX_MdStart && !EX_BranchTaken;
        w_lu       = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
        w_st       = IF_ID_MdUse && (w_md_busy || ID_EX_MdStart);
        w_stall    = rst_n && (w_lu || w_st) && !EX_BranchTaken;
    end

    // Pipeline register controls in priority order: branch, stall, jump, normal.
    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        if (rst_n) begin
            if (EX_BranchTaken) begin
                PC_Write     = 1'b1;
                IF_ID_Write  = 1'b1;
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (w_stall) begin
                ID_EX_Bubble = 1'b1;
            end else if (ID_Jump) begin
                PC_Write     = 1'b1;
                IF_ID_Write  = 1'b1;
                IF_ID_Flush  = 1'b1;
            end else begin
                PC_Write     = 1'b1;
                IF_ID_Write  = 1'b1;
            end
        end
    end

    assign MD_Start   = w_md_start;
    assign MD_Busy    = w_md_busy;
    assign MD_Done    = w_md_done;
    assign StallCount = r_stall_cnt;

    // Mult/div busy sequencer: MD_LATENCY busy cycles after the start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_state <= S_MD_RUN;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                S_MD_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; clear wins over a concurrent stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (StallCntClr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != LP_SAT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller (MD_LATENCY=4, CNT_WIDTH=4).
module tb_hazard_stall_controller;

    localparam int BW  = 5;
    localparam int LAT = 4;
    localparam int CNW = 4;
    localparam int SAT = (1 << CNW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
    logic          IF_ID_MdUse, ID_EX_MemRead, ID_EX_MdStart;
    logic          EX_BranchTaken, ID_Jump, StallCntClr;
    logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
    logic          MD_Start, MD_Busy, MD_Done;
    logic [CNW-1:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_stall_controller #(.BIT_WIDTH(BW), .MD_LATENCY(LAT), .CNT_WIDTH(CNW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_MdUse(IF_ID_MdUse),
        .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MdStart(ID_EX_MdStart),
        .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump), .StallCntClr(StallCntClr),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .MD_Start(MD_Start), .MD_Busy(MD_Busy),
        .MD_Done(MD_Done), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          mr;
        logic [BW-1:0] exrt, rs, rt;
        logic          mduse, br, jmp;
        logic          pcw, ifw, fl, bub;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic setin(input logic mr, input logic [BW-1:0] exrt, input logic [BW-1:0] rs,
                         input logic [BW-1:0] rt, input logic mduse, input logic mds,
                         input logic br, input logic jmp, input logic clr);
        ID_EX_MemRead = mr;  ID_EX_Rt = exrt; IF_ID_Rs = rs; IF_ID_Rt = rt;
        IF_ID_MdUse = mduse; ID_EX_MdStart = mds; EX_BranchTaken = br;
        ID_Jump = jmp; StallCntClr = clr;
    endtask

    task automatic chk_ctl(input string nm, input logic pcw, input logic ifw,
                           input logic fl, input logic bub);
        chk({nm, ".pcw"}, 32'(PC_Write), 32'(pcw));
        chk({nm, ".ifw"}, 32'(IF_ID_Write), 32'(ifw));
        chk({nm, ".flush"}, 32'(IF_ID_Flush), 32'(fl));
        chk({nm, ".bubble"}, 32'(ID_EX_Bubble), 32'(bub));
    endtask

    // Next clock cycle with new inputs, sampled 1 time unit after the falling edge.
    task automatic nextcyc();
        @(negedge clk);
    endtask

    initial begin
        int md_left, mcnt, c0;
        logic lu, busy, st, stall, start;
        logic mr, mduse, mds, br, jmp, clr;
        logic [BW-1:0] exrt, rs, rt;

        // ---- reset: outputs forced low even with branch/jump requested ----
        rst_n = 1'b0;
        setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #3;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.md_start", 32'(MD_Start), 0);
        chk("reset.md_busy", 32'(MD_Busy), 0);
        chk("reset.count", 32'(StallCount), 0);
        nextcyc();
        rst_n = 1'b1;
        setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_ctl("post_reset", 1'b1, 1'b1, 1'b0, 1'b0);

        // ---- table: combinational priority, counter held clear ----
        vec[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 5'd8, 5'd8, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vec[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[7]  = '{1'b1, 5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vec[9]  = '{1'b1, 5'd7, 5'd6, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            nextcyc();
            setin(vec[i].mr, vec[i].exrt, vec[i].rs, vec[i].rt, vec[i].mduse, 1'b0,
                  vec[i].br, vec[i].jmp, 1'b1);
            #1;
            chk_ctl($sformatf("vec%0d", i), vec[i].pcw, vec[i].ifw, vec[i].fl, vec[i].bub);
        end

        // ---- load-use lasts one cycle, counter 0 -> 1 ----
        nextcyc(); setin(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk_ctl("lu_stall", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_stall.count", 32'(StallCount), 0);
        nextcyc(); setin(1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_after.count", 32'(StallCount), 1);

        // ---- MD sequence with dependent MdUse held in ID ----
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; chk("md0.start", 32'(MD_Start), 1);
        chk("md0.busy", 32'(MD_Busy), 0);
        chk_ctl("md0", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= LAT; i++) begin
            nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("md%0d.busy", i), 32'(MD_Busy), 1);
            chk($sformatf("md%0d.done", i), 32'(MD_Done), (i == LAT) ? 1 : 0);
            chk($sformatf("md%0d.start", i), 32'(MD_Start), 0);
            chk($sformatf("md%0d.pcw", i), 32'(PC_Write), 0);
        end
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk("md5.busy", 32'(MD_Busy), 0);
        chk_ctl("md5", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("md5.count", 32'(StallCount), LAT + 1);

        // ---- branch during MD_RUN, branch cancelling a load-use ----
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; chk("brmd0.start", 32'(MD_Start), 1);
        nextcyc(); setin(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; chk_ctl("brlu", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("brmd1.busy", 32'(MD_Busy), 1);
        c0 = int'(StallCount);
        for (int i = 2; i <= LAT; i++) begin
            nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("brmd%0d.busy", i), 32'(MD_Busy), 1);
            chk($sformatf("brmd%0d.done", i), 32'(MD_Done), (i == LAT) ? 1 : 0);
        end
        chk("brlu.count", 32'(StallCount), 32'(c0));
        nextcyc(); #1; chk("brmd5.busy", 32'(MD_Busy), 0);

        // ---- jump concurrent with load-use: stall first, jump next ----
        nextcyc(); setin(1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1; chk_ctl("jmp_lu", 1'b0, 1'b0, 1'b0, 1'b1);
        nextcyc(); setin(1'b0, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1; chk_ctl("jmp_next", 1'b1, 1'b1, 1'b1, 1'b0);

        // ---- saturation and clear-with-stall ----
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            nextcyc(); setin(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk("sat.count", 32'(StallCount), SAT);
        nextcyc(); setin(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1; chk("clr_stall.pcw", 32'(PC_Write), 0);
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk("clr_stall.count", 32'(StallCount), 0);

        // ---- async reset in cycle 2 of MD_RUN ----
        nextcyc(); setin(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextcyc(); setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1; chk("rst_pre.busy", 32'(MD_Busy), 1);
        #2; rst_n = 1'b0;
        #1; chk("rst_mid.busy", 32'(MD_Busy), 0);
        chk("rst_mid.done", 32'(MD_Done), 0);
        chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.count", 32'(StallCount), 0);
        nextcyc(); rst_n = 1'b1;
        setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; chk_ctl("rst_rel", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < LAT + 1; i++) begin
            nextcyc(); #1;
            chk($sformatf("rst_rel%0d.done", i), 32'(MD_Done), 0);
            chk($sformatf("rst_rel%0d.busy", i), 32'(MD_Busy), 0);
        end
        chk("rst_rel.count", 32'(StallCount), 0);

        // ---- randomized run against a cycle-count reference model ----
        md_left = 0;   // busy cycles still to come, including the current one
        mcnt    = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            nextcyc();
            mr    = ($urandom_range(0, 9) < 3);
            exrt  = BW'($urandom_range(0, 3));
            rs    = BW'($urandom_range(0, 3));
            rt    = BW'($urandom_range(0, 3));
            mduse = ($urandom_range(0, 9) < 3);
            br    = ($urandom_range(0, 9) == 0);
            jmp   = ($urandom_range(0, 9) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            mds   = (md_left == 0) && !br && ($urandom_range(0, 9) < 2);
            setin(mr, exrt, rs, rt, mduse, mds, br, jmp, clr);
            #1;
            busy  = (md_left > 0);
            lu    = mr && (exrt != 0) && (exrt == rs || exrt == rt);
            st    = mduse && (busy || mds);
            stall = (lu || st) && !br;
            start = !busy && mds && !br;
            chk_ctl($sformatf("rnd%0d", cyc), !stall, !stall, br || (!stall && jmp), br || stall);
            chk($sformatf("rnd%0d.start", cyc), 32'(MD_Start), 32'(start));
            chk($sformatf("rnd%0d.busy", cyc), 32'(MD_Busy), 32'(busy));
            chk($sformatf("rnd%0d.done", cyc), 32'(MD_Done), (md_left == 1) ? 1 : 0);
            chk($sformatf("rnd%0d.count", cyc), 32'(StallCount), 32'(mcnt));
            if (start) md_left = LAT;
            else if (md_left > 0) md_left--;
            if (clr) mcnt = 0;
            else if (stall && mcnt < SAT) mcnt++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
